// File: rtl/pspi_pkg.sv
// Shared PSPI definitions: receiver state encoding, default link geometry
// and the parity helper also used by the master's frame generator.
package pspi_pkg;

    localparam int DEF_FRAME_W     = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // XOR-reduction of the payload; zero-extended inputs leave the result unchanged.
    function automatic logic parity_of(input logic [31:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/pspi_sync.sv
// STAGES-deep single-bit synchroniser with a selectable reset level, used to
// bring each asynchronous PSPI link pin into the slave clock domain.
module pspi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pspi_slave_rx.sv
// PSPI slave receive path: deserialises MSB-first frames, checks/strips the
// even-parity LSB. Optional error counter enabled by PSPI_RX_ERR_CNT_EN.
module pspi_slave_rx
    import pspi_pkg::*;
#(
    parameter int FRAME_W     = DEF_FRAME_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    output logic               parity_err,
    output logic               frame_abort,
    output logic               busy
`ifdef PSPI_RX_ERR_CNT_EN
   ,output logic [7:0]         err_cnt
`endif
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;

    state_t             state_d,       state_q;
    logic [CNT_W-1:0]   cnt_d,         cnt_q;
    logic [FRAME_W-1:0] shreg_d,       shreg_q;
    logic [FRAME_W-1:0] rx_data_d,     rx_data_q;
    logic               rx_valid_d,    rx_valid_q;
    logic               parity_err_d,  parity_err_q;
    logic               frame_abort_d, frame_abort_q;
    logic               sclk_d,        sclk_q;

    pspi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .q     (sclk_s)
    );

    pspi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ss_n),
        .q     (ss_s)
    );

    pspi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mosi),
        .q     (mosi_s)
    );

    assign sclk_d    = sclk_s;
    assign sclk_rise = sclk_s & ~sclk_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        rx_data_d     = rx_data_q;
        parity_err_d  = parity_err_q;
        rx_valid_d    = 1'b0;
        frame_abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!ss_s) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The final edge wins over a simultaneous deselect so the frame completes.
                if (sclk_rise && (cnt_q == LAST_BIT || !ss_s)) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = CHECK;
                    end
                end else if (ss_s) begin
                    frame_abort_d = (cnt_q != '0);
                    cnt_d         = '0;
                    state_d       = IDLE;
                end
            end
            CHECK: begin
                cnt_d      = '0;
                rx_valid_d = 1'b1;
                if (en) begin
                    rx_data_d    = {1'b0, shreg_q[FRAME_W-1:1]};
                    parity_err_d = shreg_q[0] ^ parity_of(32'(shreg_q[FRAME_W-1:1]));
                end else begin
                    rx_data_d    = shreg_q;
                    parity_err_d = 1'b0;
                end
                state_d = ss_s ? IDLE : SHIFT;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            sclk_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_abort_q <= frame_abort_d;
            sclk_q        <= sclk_d;
        end
    end

`ifdef PSPI_RX_ERR_CNT_EN
    logic [7:0] err_cnt_d, err_cnt_q;

    // Counts parity failures and aborted frames, saturating rather than wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (((state_q == CHECK) && parity_err_d) || frame_abort_d) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_abort = frame_abort_q;
    assign busy        = (state_q == SHIFT) || (state_q == CHECK);

endmodule

// File: tb/tb_pspi_slave_rx.sv
// Directed self-checking bench for pspi_slave_rx; covers err_cnt when
// PSPI_RX_ERR_CNT_EN is defined.
module tb_pspi_slave_rx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_abort;
    logic       busy;
`ifdef PSPI_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checkCount = 0;
    int failCount  = 0;

    int         validCount = 0;
    int         abortCount = 0;
    logic [7:0] lastData   = 8'h00;
    logic [7:0] prevData   = 8'h00;
    logic       lastPerr   = 1'b0;

    int startValid;
    int startAbort;

    pspi_slave_rx #(.FRAME_W(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_abort (frame_abort),
        .busy        (busy)
`ifdef PSPI_RX_ERR_CNT_EN
       ,.err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse observer: counts strobe cycles and records delivered words.
    always @(negedge clk) begin
        if (rx_valid) begin
            validCount = validCount + 1;
            prevData   = lastData;
            lastData   = rx_data;
            lastPerr   = parity_err;
        end
        if (frame_abort) begin
            abortCount = abortCount + 1;
        end
    end

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Shifts the top nbits of frame MSB-first; each sclk phase lasts 6 clk.
    task automatic applyStimulus(input logic [7:0] frame, input int nbits);
        logic [7:0] f;
        f = frame;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = f[7 - i];
            waitClocks(6);
            sclk = 1'b1;
            waitClocks(6);
        end
        sclk = 1'b0;
        waitClocks(6);
    endtask

    task automatic markStart();
        startValid = validCount;
        startAbort = abortCount;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        sclk  = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        waitClocks(3);
        $display("[TB] reset state");
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("reset_parity_err", 32'(parity_err), 32'h0);
        checkOutput("reset_frame_abort", 32'(frame_abort), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        waitClocks(4);

        $display("[TB] en=1 frame 0x6A");
        markStart();
        ss_n = 1'b0;
        waitClocks(4);
        checkOutput("busy_selected", 32'(busy), 32'h1);
        applyStimulus(8'h6A, 8);
        ss_n = 1'b1;
        waitClocks(8);
        checkOutput("t1_valid_count", 32'(validCount - startValid), 32'd1);
        checkOutput("t1_rx_data", 32'(rx_data), 32'h35);
        checkOutput("t1_parity_err", 32'(parity_err), 32'h0);
        checkOutput("t1_abort_count", 32'(abortCount - startAbort), 32'd0);
        checkOutput("t1_busy_idle", 32'(busy), 32'h0);
`ifdef PSPI_RX_ERR_CNT_EN
        checkOutput("t1_err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("[TB] en=1 frame 0x6B bad parity");
        markStart();
        ss_n = 1'b0;
        applyStimulus(8'h6B, 8);
        ss_n = 1'b1;
        waitClocks(8);
        checkOutput("t2_valid_count", 32'(validCount - startValid), 32'd1);
        checkOutput("t2_rx_data", 32'(rx_data), 32'h35);
        checkOutput("t2_parity_err", 32'(parity_err), 32'h1);
`ifdef PSPI_RX_ERR_CNT_EN
        checkOutput("t2_err_cnt", 32'(err_cnt), 32'd1);
`endif

        $display("[TB] en=0 frame 0xA5");
        markStart();
        en   = 1'b0;
        ss_n = 1'b0;
        applyStimulus(8'hA5, 8);
        ss_n = 1'b1;
        waitClocks(8);
        en = 1'b1;
        checkOutput("t3_valid_count", 32'(validCount - startValid), 32'd1);
        checkOutput("t3_rx_data", 32'(rx_data), 32'hA5);
        checkOutput("t3_parity_err", 32'(parity_err), 32'h0);

        $display("[TB] back-to-back 0x6A, 0x00");
        markStart();
        ss_n = 1'b0;
        applyStimulus(8'h6A, 8);
        applyStimulus(8'h00, 8);
        ss_n = 1'b1;
        waitClocks(8);
        checkOutput("t4_valid_count", 32'(validCount - startValid), 32'd2);
        checkOutput("t4_first_data", 32'(prevData), 32'h35);
        checkOutput("t4_second_data", 32'(lastData), 32'h00);
        checkOutput("t4_second_perr", 32'(lastPerr), 32'h0);
        checkOutput("t4_abort_count", 32'(abortCount - startAbort), 32'd0);

        $display("[TB] abort after 5 bits");
        markStart();
        ss_n = 1'b0;
        applyStimulus(8'hFF, 5);
        ss_n = 1'b1;
        waitClocks(8);
        checkOutput("t5_abort_count", 32'(abortCount - startAbort), 32'd1);
        checkOutput("t5_valid_count", 32'(validCount - startValid), 32'd0);
        checkOutput("t5_rx_data_held", 32'(rx_data), 32'h00);
        checkOutput("t5_busy", 32'(busy), 32'h0);
`ifdef PSPI_RX_ERR_CNT_EN
        checkOutput("t5_err_cnt", 32'(err_cnt), 32'd2);
`endif
        markStart();
        ss_n = 1'b0;
        applyStimulus(8'h6A, 8);
        ss_n = 1'b1;
        waitClocks(8);
        checkOutput("t5b_valid_count", 32'(validCount - startValid), 32'd1);
        checkOutput("t5b_rx_data", 32'(rx_data), 32'h35);

        $display("[TB] reset after 4 bits");
        markStart();
        ss_n = 1'b0;
        applyStimulus(8'hC3, 4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rx_data", 32'(rx_data), 32'h00);
        checkOutput("t6_rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("t6_parity_err", 32'(parity_err), 32'h0);
        checkOutput("t6_frame_abort", 32'(frame_abort), 32'h0);
        checkOutput("t6_busy", 32'(busy), 32'h0);
`ifdef PSPI_RX_ERR_CNT_EN
        checkOutput("t6_err_cnt", 32'(err_cnt), 32'd0);
`endif
        ss_n = 1'b1;
        waitClocks(3);
        rst_n = 1'b1;
        waitClocks(6);
        checkOutput("t6_no_strobe", 32'(validCount - startValid + abortCount - startAbort), 32'd0);
        markStart();
        ss_n = 1'b0;
        applyStimulus(8'h6A, 8);
        ss_n = 1'b1;
        waitClocks(8);
        checkOutput("t6b_valid_count", 32'(validCount - startValid), 32'd1);
        checkOutput("t6b_rx_data", 32'(rx_data), 32'h35);
        checkOutput("t6b_parity_err", 32'(parity_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
